// File: rtl/ysyx_23060025_mem_stage_pkg.sv
// Shared constants, bus layouts and store helpers for the memory-access stage.
package ysyx_23060025_mem_stage_pkg;

  localparam int unsigned DataLen = 32;

  // Load kinds carried in load_type (0 = not a load)
  localparam logic [2:0] LOAD_NONE = 3'd0;
  localparam logic [2:0] LOAD_LB   = 3'd1;
  localparam logic [2:0] LOAD_LH   = 3'd2;
  localparam logic [2:0] LOAD_LW   = 3'd3;
  localparam logic [2:0] LOAD_LBU  = 3'd4;
  localparam logic [2:0] LOAD_LHU  = 3'd5;

  // Store kinds carried in store_type (0 = not a store)
  localparam logic [1:0] STORE_NONE = 2'd0;
  localparam logic [1:0] STORE_SB   = 2'd1;
  localparam logic [1:0] STORE_SH   = 2'd2;
  localparam logic [1:0] STORE_SW   = 2'd3;

  // Data-memory access FSM encodings
  localparam logic [1:0] MS_IDLE = 2'd0;
  localparam logic [1:0] MS_WAIT = 2'd1;
  localparam logic [1:0] MS_DONE = 2'd2;

  // EX -> MEM bus, MSB first
  typedef struct packed {
    logic        wd;
    logic [4:0]  wreg;
    logic [31:0] alu_result;
    logic        mem_op;
    logic [31:0] store_data;
    logic [2:0]  load_type;
    logic [1:0]  store_type;
    logic [31:0] csr_wdata;
    logic [2:0]  csr_flag;
    logic [11:0] csr_waddr;
    logic [31:0] mcause;
    logic        ebreak;
    logic        fencei;
  } es_to_ms_bus_t;

  // MEM -> WB bus, MSB first; width is the sum of the listed fields
  typedef struct packed {
    logic        wd;
    logic [4:0]  wreg;
    logic [31:0] ms_result;
    logic [31:0] csr_wdata;
    logic [2:0]  csr_flag;
    logic [11:0] csr_waddr;
    logic [31:0] mcause;
    logic        ebreak;
    logic        fencei;
  } ms_to_ws_bus_t;

  localparam int unsigned ES_TO_MS_DATA_BUS    = $bits(es_to_ms_bus_t);
  localparam int unsigned MS_TO_WS_DATA_BUS    = $bits(ms_to_ws_bus_t);
  localparam int unsigned MS_TO_DS_FORWARD_BUS = 39;

  // Byte strobes for a store; SH ignores addr[0]
  function automatic logic [3:0] store_wstrb(input logic [1:0] store_type,
                                             input logic [1:0] addr_low);
    logic [3:0] strb;
    strb = 4'b0000;
    case (store_type)
      STORE_SB: strb = 4'b0001 << addr_low;
      STORE_SH: strb = 4'b0011 << {addr_low[1], 1'b0};
      STORE_SW: strb = 4'b1111;
      default:  strb = 4'b0000;
    endcase
    return strb;
  endfunction

  // Store data replicated across every lane it could land in
  function automatic logic [31:0] store_wdata(input logic [1:0]  store_type,
                                              input logic [31:0] data);
    logic [31:0] wdata;
    wdata = '0;
    case (store_type)
      STORE_SB: wdata = {4{data[7:0]}};
      STORE_SH: wdata = {2{data[15:0]}};
      STORE_SW: wdata = data;
      default:  wdata = '0;
    endcase
    return wdata;
  endfunction

endpackage

// File: rtl/ysyx_23060025_mem_stage_load_align.sv
// Selects the addressed byte/half/word from a word-aligned read and extends it.
module ysyx_23060025_mem_stage_load_align
  import ysyx_23060025_mem_stage_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  addr_low,
  input  logic [2:0]  load_type,
  output logic [31:0] load_data
);

  logic [7:0]  byte_val;
  logic [15:0] half_val;

  assign byte_val = rdata[{addr_low, 3'b000} +: 8];
  assign half_val = rdata[{addr_low[1], 4'b0000} +: 16];

  // Extend the selected lane according to the load kind
  always_comb begin
    load_data = '0;
    case (load_type)
      LOAD_LB:  load_data = {{24{byte_val[7]}}, byte_val};
      LOAD_LH:  load_data = {{16{half_val[15]}}, half_val};
      LOAD_LW:  load_data = rdata;
      LOAD_LBU: load_data = {24'd0, byte_val};
      LOAD_LHU: load_data = {16'd0, half_val};
      default:  load_data = '0;
    endcase
  end

endmodule

// File: rtl/ysyx_23060025_mem_stage.sv
// Memory-access pipeline stage: latches the EX bus, performs one outstanding
// data-memory access, and passes the result to WB and forwards it to decode.
module ysyx_23060025_mem_stage
  import ysyx_23060025_mem_stage_pkg::*;
#(
  parameter int unsigned DATA_LEN = 32
) (
  input  logic                            clock,
  input  logic                            reset,
  input  logic                            es_to_ms_valid_i,
  output logic                            ms_allowin_o,
  input  logic [ES_TO_MS_DATA_BUS-1:0]    es_to_ms_bus,
  output logic                            ms_to_ws_valid_o,
  input  logic                            ws_allowin_i,
  output logic [MS_TO_WS_DATA_BUS-1:0]    ms_to_ws_bus,
  output logic [MS_TO_DS_FORWARD_BUS-1:0] ms_to_ds_forward_bus,
  output logic                            data_req_valid_o,
  input  logic                            data_req_ready_i,
  output logic                            data_req_wen_o,
  output logic [DATA_LEN-1:0]             data_req_addr_o,
  output logic [3:0]                      data_req_wstrb_o,
  output logic [DATA_LEN-1:0]             data_req_wdata_o,
  input  logic                            data_resp_valid_i,
  input  logic [DATA_LEN-1:0]             data_resp_rdata_i
);

  logic                         ms_valid_q;
  logic [ES_TO_MS_DATA_BUS-1:0] bus_q;
  logic [1:0]                   state_q, state_d;
  logic [31:0]                  load_data_q, load_data_d;
  logic [31:0]                  aligned_data;
  es_to_ms_bus_t                es;
  ms_to_ws_bus_t                ws;
  logic                         is_load;
  logic                         ms_ready_go;
  logic [31:0]                  ms_result;
  logic                         forward_enable;
  logic                         dep_need_stall;

  assign es      = bus_q;
  assign is_load = (es.load_type != LOAD_NONE);

  // Non-memory ops pass straight through; memory ops wait for the access to finish
  assign ms_ready_go      = !es.mem_op || (state_q == MS_DONE);
  assign ms_allowin_o     = !ms_valid_q || (ms_ready_go && ws_allowin_i);
  assign ms_to_ws_valid_o = ms_valid_q && ms_ready_go;

  // Pipeline valid bit and instruction latch
  always_ff @(posedge clock) begin
    if (reset) begin
      ms_valid_q <= 1'b0;
      bus_q      <= '0;
    end else if (ms_allowin_o) begin
      ms_valid_q <= es_to_ms_valid_i;
      if (es_to_ms_valid_i) begin
        bus_q <= es_to_ms_bus;
      end
    end
  end

  ysyx_23060025_mem_stage_load_align u_load_align (
    .rdata     (data_resp_rdata_i),
    .addr_low  (es.alu_result[1:0]),
    .load_type (es.load_type),
    .load_data (aligned_data)
  );

  // Request is only presented in IDLE and held until the memory takes it
  assign data_req_valid_o = (state_q == MS_IDLE) && ms_valid_q && es.mem_op;
  assign data_req_wen_o   = (es.store_type != STORE_NONE);
  assign data_req_addr_o  = es.alu_result;
  assign data_req_wstrb_o = store_wstrb(es.store_type, es.alu_result[1:0]);
  assign data_req_wdata_o = store_wdata(es.store_type, es.store_data);

  // Access FSM next state; responses outside WAIT are dropped
  always_comb begin
    state_d     = state_q;
    load_data_d = load_data_q;
    case (state_q)
      MS_IDLE: begin
        if (data_req_valid_o && data_req_ready_i) begin
          state_d = MS_WAIT;
        end
      end
      MS_WAIT: begin
        if (data_resp_valid_i) begin
          load_data_d = aligned_data;
          state_d     = MS_DONE;
        end
      end
      MS_DONE: begin
        if (ws_allowin_i) begin
          state_d = MS_IDLE;
        end
      end
      default: state_d = MS_IDLE;
    endcase
  end

  // Access FSM state and captured load data
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= MS_IDLE;
      load_data_q <= '0;
    end else begin
      state_q     <= state_d;
      load_data_q <= load_data_d;
    end
  end

  assign ms_result = is_load ? load_data_q : es.alu_result;

  // Decode must stall on a load whose data has not come back yet
  assign forward_enable = ms_valid_q && es.wd && (es.wreg != 5'd0);
  assign dep_need_stall = ms_valid_q && is_load && (state_q != MS_DONE);
  assign ms_to_ds_forward_bus = {dep_need_stall, forward_enable, es.wreg, ms_result};

  // WB bus assembly; CSR and trap fields pass through untouched
  always_comb begin
    ws           = '0;
    ws.wd        = es.wd;
    ws.wreg      = es.wreg;
    ws.ms_result = ms_result;
    ws.csr_wdata = es.csr_wdata;
    ws.csr_flag  = es.csr_flag;
    ws.csr_waddr = es.csr_waddr;
    ws.mcause    = es.mcause;
    ws.ebreak    = es.ebreak;
    ws.fencei    = es.fencei;
  end

  assign ms_to_ws_bus = ws;

endmodule

// File: tb/tb_ysyx_23060025_mem_stage.sv
// Directed bench for the memory stage with a WB-side scoreboard.
module tb_ysyx_23060025_mem_stage;

  logic         clock;
  logic         reset;
  logic         es_to_ms_valid_i;
  logic         ms_allowin_o;
  logic [156:0] es_to_ms_bus;
  logic         ms_to_ws_valid_o;
  logic         ws_allowin_i;
  logic [118:0] ms_to_ws_bus;
  logic [38:0]  ms_to_ds_forward_bus;
  logic         data_req_valid_o;
  logic         data_req_ready_i;
  logic         data_req_wen_o;
  logic [31:0]  data_req_addr_o;
  logic [3:0]   data_req_wstrb_o;
  logic [31:0]  data_req_wdata_o;
  logic         data_resp_valid_i;
  logic [31:0]  data_resp_rdata_i;

  int checks;
  int errors;
  int req_count;
  int req_base;
  logic [118:0] exp_q[$];

  ysyx_23060025_mem_stage dut (
    .clock                (clock),
    .reset                (reset),
    .es_to_ms_valid_i     (es_to_ms_valid_i),
    .ms_allowin_o         (ms_allowin_o),
    .es_to_ms_bus         (es_to_ms_bus),
    .ms_to_ws_valid_o     (ms_to_ws_valid_o),
    .ws_allowin_i         (ws_allowin_i),
    .ms_to_ws_bus         (ms_to_ws_bus),
    .ms_to_ds_forward_bus (ms_to_ds_forward_bus),
    .data_req_valid_o     (data_req_valid_o),
    .data_req_ready_i     (data_req_ready_i),
    .data_req_wen_o       (data_req_wen_o),
    .data_req_addr_o      (data_req_addr_o),
    .data_req_wstrb_o     (data_req_wstrb_o),
    .data_req_wdata_o     (data_req_wdata_o),
    .data_resp_valid_i    (data_resp_valid_i),
    .data_resp_rdata_i    (data_resp_rdata_i)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic [156:0] mk_es(input logic wd, input logic [4:0] wreg,
                                         input logic [31:0] alu, input logic mem_op,
                                         input logic [31:0] sdata, input logic [2:0] lt,
                                         input logic [1:0] st, input logic [31:0] tag);
    return {wd, wreg, alu, mem_op, sdata, lt, st, tag, tag[2:0], tag[11:0], ~tag, tag[0], tag[1]};
  endfunction

  function automatic logic [118:0] mk_ws(input logic wd, input logic [4:0] wreg,
                                         input logic [31:0] res, input logic [31:0] tag);
    return {wd, wreg, res, tag, tag[2:0], tag[11:0], ~tag, tag[0], tag[1]};
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  initial begin
    checks = 0; errors = 0; req_count = 0;
    reset = 1'b1; es_to_ms_valid_i = 1'b0; es_to_ms_bus = '0; ws_allowin_i = 1'b1;
    data_req_ready_i = 1'b0; data_resp_valid_i = 1'b0; data_resp_rdata_i = '0;

    // WB-side scoreboard and request counter, sampled on the falling edge
    fork
      forever begin
        @(negedge clock);
        if (!reset && ms_to_ws_valid_o && ws_allowin_i) begin
          chk("wb_bus", {9'd0, ms_to_ws_bus}, (exp_q.size() > 0) ? {9'd0, exp_q.pop_front()} : 'x);
        end
        if (data_req_valid_o && data_req_ready_i) req_count++;
      end
    join_none

    // Reset state
    tick(); tick(); #1;
    chk("rst_allowin", ms_allowin_o, 1'b1);
    chk("rst_ws_valid", ms_to_ws_valid_o, 1'b0);
    chk("rst_req_valid", data_req_valid_o, 1'b0);
    chk("rst_ws_bus", ms_to_ws_bus, '0);
    chk("rst_fwd", ms_to_ds_forward_bus, '0);
    reset = 1'b0;

    // ALU pass-through
    tick();
    es_to_ms_valid_i = 1'b1;
    es_to_ms_bus = mk_es(1'b1, 5'd5, 32'h1234, 1'b0, 32'h0, 3'd0, 2'd0, 32'hA5A5_0F0F);
    exp_q.push_back(mk_ws(1'b1, 5'd5, 32'h1234, 32'hA5A5_0F0F));
    tick();
    es_to_ms_valid_i = 1'b0; #1;
    chk("alu_ws_valid", ms_to_ws_valid_o, 1'b1);
    chk("alu_no_req", data_req_valid_o, 1'b0);
    chk("alu_fwd", ms_to_ds_forward_bus, {1'b0, 1'b1, 5'd5, 32'h1234});
    tick(); #1;
    chk("alu_drained", ms_to_ws_valid_o, 1'b0);

    // LB with sign extension, response two cycles after the request
    es_to_ms_valid_i = 1'b1; data_req_ready_i = 1'b1;
    es_to_ms_bus = mk_es(1'b1, 5'd7, 32'h8000_0003, 1'b1, 32'h0, 3'd1, 2'd0, 32'h1111_0001);
    exp_q.push_back(mk_ws(1'b1, 5'd7, 32'hFFFF_FF80, 32'h1111_0001));
    tick();
    es_to_ms_valid_i = 1'b0; #1;
    chk("lb_req", {data_req_valid_o, data_req_wen_o, data_req_wstrb_o}, {1'b1, 1'b0, 4'b0000});
    chk("lb_addr", data_req_addr_o, 32'h8000_0003);
    chk("lb_stall_idle", ms_to_ds_forward_bus[38:37], 2'b11);
    chk("lb_ws_valid_idle", ms_to_ws_valid_o, 1'b0);
    tick();
    data_req_ready_i = 1'b0; #1;
    chk("lb_wait_no_req", data_req_valid_o, 1'b0);
    chk("lb_stall_wait", ms_to_ds_forward_bus[38], 1'b1);
    tick();
    data_resp_valid_i = 1'b1; data_resp_rdata_i = 32'h80FF_1234;
    tick();
    data_resp_valid_i = 1'b0; data_resp_rdata_i = '0; #1;
    chk("lb_done_stall", ms_to_ds_forward_bus[38], 1'b0);
    chk("lb_fwd_result", ms_to_ds_forward_bus[31:0], 32'hFFFF_FF80);
    tick();

    // SH: upper half strobes, replicated data
    es_to_ms_valid_i = 1'b1;
    es_to_ms_bus = mk_es(1'b0, 5'd0, 32'h8000_0002, 1'b1, 32'hABCD_5678, 3'd0, 2'd2, 32'h2222_0002);
    exp_q.push_back(mk_ws(1'b0, 5'd0, 32'h8000_0002, 32'h2222_0002));
    tick();
    es_to_ms_valid_i = 1'b0; data_req_ready_i = 1'b1; #1;
    chk("sh_req", {data_req_valid_o, data_req_wen_o, data_req_wstrb_o}, {1'b1, 1'b1, 4'b1100});
    chk("sh_wdata", data_req_wdata_o, 32'h5678_5678);
    tick();
    data_req_ready_i = 1'b0; data_resp_valid_i = 1'b1; data_resp_rdata_i = 32'hDEAD_0000; #1;
    chk("sh_no_stall", ms_to_ds_forward_bus[38:37], 2'b00);
    tick();
    data_resp_valid_i = 1'b0; #1;
    chk("sh_ws_valid", ms_to_ws_valid_o, 1'b1);
    tick();

    // SB at byte 1
    es_to_ms_valid_i = 1'b1; data_req_ready_i = 1'b1;
    es_to_ms_bus = mk_es(1'b0, 5'd0, 32'h8000_0041, 1'b1, 32'h1234_00A5, 3'd0, 2'd1, 32'h3333_0003);
    exp_q.push_back(mk_ws(1'b0, 5'd0, 32'h8000_0041, 32'h3333_0003));
    tick();
    es_to_ms_valid_i = 1'b0; #1;
    chk("sb_wstrb", data_req_wstrb_o, 4'b0010);
    chk("sb_wdata", data_req_wdata_o, 32'hA5A5_A5A5);
    tick();
    data_req_ready_i = 1'b0; data_resp_valid_i = 1'b1;
    tick();
    data_resp_valid_i = 1'b0;
    tick();

    // LW held in DONE while WB refuses; a waiting instruction must not enter
    es_to_ms_valid_i = 1'b1; data_req_ready_i = 1'b1;
    es_to_ms_bus = mk_es(1'b1, 5'd8, 32'h8000_0010, 1'b1, 32'h0, 3'd3, 2'd0, 32'h4444_0004);
    exp_q.push_back(mk_ws(1'b1, 5'd8, 32'hDEAD_BEEF, 32'h4444_0004));
    tick();
    es_to_ms_valid_i = 1'b0;
    tick();
    data_resp_valid_i = 1'b1; data_resp_rdata_i = 32'hDEAD_BEEF; ws_allowin_i = 1'b0;
    tick();
    data_resp_valid_i = 1'b0;
    es_to_ms_valid_i = 1'b1;
    es_to_ms_bus = mk_es(1'b1, 5'd9, 32'h0000_0055, 1'b0, 32'h0, 3'd0, 2'd0, 32'h5555_0005);
    exp_q.push_back(mk_ws(1'b1, 5'd9, 32'h0000_0055, 32'h5555_0005));
    for (int i = 0; i < 3; i++) begin
      data_resp_valid_i = (i == 1); data_resp_rdata_i = 32'h0;
      #1;
      chk("hold_allowin", ms_allowin_o, 1'b0);
      chk("hold_valid_result", {ms_to_ws_valid_o, ms_to_ws_bus[112:81]}, {1'b1, 32'hDEAD_BEEF});
      chk("hold_no_req", data_req_valid_o, 1'b0);
      tick();
    end
    data_resp_valid_i = 1'b0; ws_allowin_i = 1'b1;
    tick();
    es_to_ms_valid_i = 1'b0;
    tick();

    // Back-to-back LW then LHU: second enters as first retires, two requests total
    req_base = req_count;
    es_to_ms_valid_i = 1'b1; data_req_ready_i = 1'b1;
    es_to_ms_bus = mk_es(1'b1, 5'd10, 32'h8000_0020, 1'b1, 32'h0, 3'd3, 2'd0, 32'h6666_0006);
    exp_q.push_back(mk_ws(1'b1, 5'd10, 32'h1234_5678, 32'h6666_0006));
    tick();
    es_to_ms_bus = mk_es(1'b1, 5'd11, 32'h8000_0022, 1'b1, 32'h0, 3'd5, 2'd0, 32'h7777_0007);
    exp_q.push_back(mk_ws(1'b1, 5'd11, 32'h0000_8001, 32'h7777_0007));
    #1;
    chk("b2b_blocked", ms_allowin_o, 1'b0);
    tick();
    data_resp_valid_i = 1'b1; data_resp_rdata_i = 32'h1234_5678;
    tick();
    data_resp_valid_i = 1'b0; #1;
    chk("b2b_allowin_done", ms_allowin_o, 1'b1);
    tick();
    es_to_ms_valid_i = 1'b0; #1;
    chk("b2b_second_req", {data_req_valid_o, data_req_addr_o}, {1'b1, 32'h8000_0022});
    tick();
    data_resp_valid_i = 1'b1; data_resp_rdata_i = 32'h8001_0000;
    tick();
    data_resp_valid_i = 1'b0;
    tick(); #1;
    chk("b2b_req_count", req_count - req_base, 2);

    // Reset while waiting for a response; a late response is dropped
    es_to_ms_valid_i = 1'b1; data_req_ready_i = 1'b1;
    es_to_ms_bus = mk_es(1'b1, 5'd12, 32'h8000_0030, 1'b1, 32'h0, 3'd3, 2'd0, 32'h8888_0008);
    tick();
    es_to_ms_valid_i = 1'b0;
    tick();
    data_req_ready_i = 1'b0; reset = 1'b1;
    tick();
    reset = 1'b0; #1;
    chk("mid_rst_state", {ms_to_ws_valid_o, data_req_valid_o, ms_allowin_o}, 3'b001);
    chk("mid_rst_bus", ms_to_ws_bus, '0);
    data_resp_valid_i = 1'b1; data_resp_rdata_i = 32'hFFFF_FFFF;
    tick();
    data_resp_valid_i = 1'b0; #1;
    chk("late_resp_ignored", {ms_to_ws_valid_o, ms_to_ds_forward_bus}, '0);
    tick();

    chk("wb_all_retired", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
